// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the toy ALU execute-stage blocks
package alu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DEF_WIDTH = 32;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sub_w.sv
// sub_w: a + ~b + 1 subtractor in generate/propagate form; c=1 means a >= b
module sub_w #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         c
);
    logic [W-1:0] g, p;
    logic [W:0]   cy;
    assign g = a & ~b;
    assign p = a ^ ~b;
    always_comb begin
        cy[0] = 1'b1;
        for (int i = 0; i < W; i++) cy[i+1] = g[i] | (p[i] & cy[i]);
    end
    assign d = p ^ cy[W-1:0];
    assign c = cy[W];
endmodule

// File: rtl/div32_seq.sv
// div32_seq: restoring unsigned divider, one shift-and-subtract step per clock
module div32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_w(WIDTH);
    state_t state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg, dvs, q_nxt;
    logic [WIDTH:0]   r, s, d, r_nxt;
    logic             c, last, r_msb_unused;
    // The remainder never exceeds the divisor, so r's top bit is only a carry slot.
    assign r_msb_unused = r[WIDTH];
    assign s     = {r[WIDTH-1:0], q_reg[WIDTH-1]};
    assign r_nxt = c ? d : s;
    assign q_nxt = {q_reg[WIDTH-2:0], c};
    assign last  = cnt == CW'(WIDTH - 1);
    sub_w #(.W(WIDTH + 1)) u_sub (.a(s), .b({1'b0, dvs}), .d(d), .c(c));
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cnt         <= '0;
            q_reg       <= '0;
            r           <= '0;
            dvs         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b1;
                        state       <= DONE;
                    end else if (start) begin
                        dvs         <= divisor;
                        q_reg       <= dividend;
                        r           <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    r     <= r_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed table, corner sequences and random divides vs an arithmetic model
module tb_div32_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    div32_seq dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [31:0] a, b, q, r;
        logic        z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat = edges after the accepting edge before done is visible
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (lat <= 100) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) break;
            lat++;
        end
    endtask

    task automatic after_done(input string name);
        @(negedge clk);
        chk({name, " busy drop"}, 32'(busy), 32'd0);
        chk({name, " done pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int lat;
        bit bok;
        kick(a, b);
        wait_done(lat, bok);
        chk({name, " latency"}, 32'(lat), b == 0 ? 32'd0 : 32'd32);
        chk({name, " busy"}, 32'(bok), 32'd1);
        chk({name, " quotient"}, quotient, eq);
        chk({name, " remainder"}, remainder, er);
        chk({name, " dbz"}, 32'(div_by_zero), 32'(ez));
        after_done(name);
    endtask

    initial begin
        vec_t tbl[7];
        int lat;
        bit bok;
        tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        tbl[3] = '{32'd5, 32'd10, 32'd0, 32'd5, 1'b0};
        tbl[4] = '{32'd0, 32'd3, 32'd0, 32'd0, 1'b0};
        tbl[5] = '{32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1};
        tbl[6] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 7; i++)
            run($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

        // starts mid-CALC and in the DONE cycle are ignored; start held into IDLE is taken
        kick(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bok);
        chk("ignore quotient", quotient, 32'd14);
        chk("ignore remainder", remainder, 32'd2);
        dividend = 32'd9;
        divisor  = 32'd4;
        start    = 1'b1;
        @(negedge clk);
        chk("done-start idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bok);
        chk("retry latency", 32'(lat), 32'd32);
        chk("retry quotient", quotient, 32'd2);
        chk("retry remainder", remainder, 32'd1);
        after_done("retry");

        // reset in the middle of a divide
        kick(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", remainder, 32'd0);
        run("post-rst 9/4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 5 == 0) a = a >> $urandom_range(0, 31);
            if (b == 0) run($sformatf("rnd%0d", i), a, b, 32'hFFFFFFFF, a, 1'b1);
            else run($sformatf("rnd%0d", i), a, b, a / b, a % b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
